// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch/decode pipeline register.
// The NOP is addi x0,x0,0, presented to decode whenever no valid beat is held.
package pipe_pkg;

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} skid_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_decode_skid_reg.sv
// IF->ID pipeline register with a one-deep skid slot, so readyF comes from a flop
// rather than from readyD. Empty or flushed slots always present NOP and PC 0.
module fetch_decode_skid_reg
   import pipe_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ROM_WIDTH  = 12,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(pipe_pkg::NOP_INSTR)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  validF,
   input  logic [DATA_WIDTH-1:0] instrF,
   input  logic [ROM_WIDTH-1:0]  pcF,
   output logic                  readyF,
   input  logic                  flushD,
   output logic                  validD,
   output logic [DATA_WIDTH-1:0] instrD,
   output logic [ROM_WIDTH-1:0]  pcD,
   input  logic                  readyD
);

   skid_state_t           state, state_n;
   logic                  out_valid, out_valid_n;
   logic [DATA_WIDTH-1:0] out_instr, out_instr_n;
   logic [ROM_WIDTH-1:0]  out_pc, out_pc_n;
   logic                  skid_valid, skid_valid_n;
   logic [DATA_WIDTH-1:0] skid_instr, skid_instr_n;
   logic [ROM_WIDTH-1:0]  skid_pc, skid_pc_n;
   logic                  fire_f, fire_d;

   assign readyF = ~skid_valid;
   assign validD = out_valid;
   assign instrD = out_instr;
   assign pcD    = out_pc;

   assign fire_f = validF & ~skid_valid;
   assign fire_d = out_valid & readyD;

   always_comb begin
      state_n      = state;
      out_valid_n  = out_valid;
      out_instr_n  = out_instr;
      out_pc_n     = out_pc;
      skid_valid_n = skid_valid;
      skid_instr_n = skid_instr;
      skid_pc_n    = skid_pc;

      // Flush wins over everything; an offered fetch beat is simply dropped.
      if (flushD) begin
         state_n      = ST_EMPTY;
         out_valid_n  = 1'b0;
         out_instr_n  = NOP_INSTR;
         out_pc_n     = '0;
         skid_valid_n = 1'b0;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (fire_f) begin
                  state_n     = ST_ONE;
                  out_valid_n = 1'b1;
                  out_instr_n = instrF;
                  out_pc_n    = pcF;
               end
            end
            ST_ONE: begin
               if (fire_f && fire_d) begin
                  out_instr_n = instrF;
                  out_pc_n    = pcF;
               end else if (fire_f) begin
                  state_n      = ST_FULL;
                  skid_valid_n = 1'b1;
                  skid_instr_n = instrF;
                  skid_pc_n    = pcF;
               end else if (fire_d) begin
                  state_n     = ST_EMPTY;
                  out_valid_n = 1'b0;
                  out_instr_n = NOP_INSTR;
                  out_pc_n    = '0;
               end
            end
            ST_FULL: begin
               if (fire_d) begin
                  state_n      = ST_ONE;
                  out_instr_n  = skid_instr;
                  out_pc_n     = skid_pc;
                  skid_valid_n = 1'b0;
               end
            end
            default: begin
               state_n      = ST_EMPTY;
               out_valid_n  = 1'b0;
               out_instr_n  = NOP_INSTR;
               out_pc_n     = '0;
               skid_valid_n = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_EMPTY;
         out_valid  <= 1'b0;
         out_instr  <= NOP_INSTR;
         out_pc     <= '0;
         skid_valid <= 1'b0;
         skid_instr <= NOP_INSTR;
         skid_pc    <= '0;
      end else begin
         state      <= state_n;
         out_valid  <= out_valid_n;
         out_instr  <= out_instr_n;
         out_pc     <= out_pc_n;
         skid_valid <= skid_valid_n;
         skid_instr <= skid_instr_n;
         skid_pc    <= skid_pc_n;
      end
   end

endmodule

// File: tb/tb_fetch_decode_skid_reg.sv
// Bench for fetch_decode_skid_reg: directed scenarios plus random traffic, all
// checked against a queue model of beats accepted from fetch but not yet consumed.
module tb_fetch_decode_skid_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] instr;
      logic [11:0] pc;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        validF;
   logic [31:0] instrF;
   logic [11:0] pcF;
   logic        readyF;
   logic        flushD;
   logic        validD;
   logic [31:0] instrD;
   logic [11:0] pcD;
   logic        readyD;

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t model_q[$];

   fetch_decode_skid_reg dut (
      .clk    (clk),
      .rst    (rst),
      .validF (validF),
      .instrF (instrF),
      .pcF    (pcF),
      .readyF (readyF),
      .flushD (flushD),
      .validD (validD),
      .instrD (instrD),
      .pcD    (pcD),
      .readyD (readyD)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   // The model holds at most two beats; the head is what decode must see.
   task automatic checkState(input string tag);
      checkOutput({tag, "_validD"}, validD, model_q.size() > 0);
      checkOutput({tag, "_instrD"}, instrD, (model_q.size() > 0) ? model_q[0].instr : NOP);
      checkOutput({tag, "_pcD"}, pcD, (model_q.size() > 0) ? model_q[0].pc : 12'h000);
      checkOutput({tag, "_readyF"}, readyF, model_q.size() < 2);
   endtask

   task automatic applyStimulus(input string tag, input logic v_f, input logic [11:0] p_f,
                                input logic r_d, input logic fl, output logic accepted);
      logic [31:0] i_f;
      logic        fire_f, fire_d;
      beat_t       b;
      i_f = 32'hC0DE_0000 | {20'h0, p_f};
      @(negedge clk);
      validF = v_f;
      instrF = i_f;
      pcF    = p_f;
      readyD = r_d;
      flushD = fl;
      #1;
      checkOutput({tag, "_readyF_pre"}, readyF, model_q.size() < 2);
      readyD = ~r_d;
      #1;
      checkOutput({tag, "_readyF_indep"}, readyF, model_q.size() < 2);
      readyD = r_d;
      fire_f   = v_f && (model_q.size() < 2);
      fire_d   = r_d && (model_q.size() > 0);
      accepted = fire_f && !fl;
      @(posedge clk);
      #1;
      if (fl) begin
         model_q.delete();
      end else begin
         if (fire_d) void'(model_q.pop_front());
         if (fire_f) begin
            b.instr = i_f;
            b.pc    = p_f;
            model_q.push_back(b);
         end
      end
      checkState(tag);
   endtask

   initial begin
      logic        acc;
      logic        pend_valid;
      logic [11:0] pend_pc;

      rst    = 1'b1;
      validF = 1'b0;
      instrF = '0;
      pcF    = '0;
      flushD = 1'b0;
      readyD = 1'b0;
      #12;
      checkState("reset");
      rst = 1'b0;

      // Fill the block, then pulse reset between clock edges.
      applyStimulus("prefill0", 1'b1, 12'h100, 1'b0, 1'b0, acc);
      applyStimulus("prefill1", 1'b1, 12'h104, 1'b0, 1'b0, acc);
      @(negedge clk);
      validF = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_q.delete();
      checkState("async_rst");
      #1 rst = 1'b0;

      // Streaming with decode always ready.
      applyStimulus("stream0", 1'b1, 12'h000, 1'b1, 1'b0, acc);
      applyStimulus("stream1", 1'b1, 12'h004, 1'b1, 1'b0, acc);
      applyStimulus("stream2", 1'b1, 12'h008, 1'b1, 1'b0, acc);
      applyStimulus("stream_end", 1'b0, 12'h000, 1'b1, 1'b0, acc);

      // Stall decode so the skid slot fills; fetch holds 0x018 until accepted.
      applyStimulus("skid0", 1'b1, 12'h010, 1'b1, 1'b0, acc);
      applyStimulus("skid1", 1'b1, 12'h014, 1'b0, 1'b0, acc);
      applyStimulus("skid_hold", 1'b1, 12'h018, 1'b0, 1'b0, acc);
      checkOutput("skid_blocked_accept", acc, 1'b0);
      applyStimulus("skid_rel0", 1'b1, 12'h018, 1'b1, 1'b0, acc);
      applyStimulus("skid_rel1", 1'b1, 12'h018, 1'b1, 1'b0, acc);
      checkOutput("skid_rel1_accept", acc, 1'b1);
      applyStimulus("skid_drain0", 1'b0, 12'h000, 1'b1, 1'b0, acc);
      applyStimulus("skid_drain1", 1'b0, 12'h000, 1'b1, 1'b0, acc);

      // Flush while full, with a beat offered in the same cycle.
      applyStimulus("fl_fill0", 1'b1, 12'h01C, 1'b0, 1'b0, acc);
      applyStimulus("fl_fill1", 1'b1, 12'h01E, 1'b0, 1'b0, acc);
      applyStimulus("flush_full", 1'b1, 12'h020, 1'b0, 1'b1, acc);
      applyStimulus("flush_after", 1'b0, 12'h000, 1'b1, 1'b0, acc);

      // Single beat drains to NOP.
      applyStimulus("drain0", 1'b1, 12'h030, 1'b1, 1'b0, acc);
      applyStimulus("drain1", 1'b0, 12'h000, 1'b1, 1'b0, acc);
      applyStimulus("drain2", 1'b0, 12'h000, 1'b1, 1'b0, acc);

      // Random traffic; fetch keeps offering the same PC until it is taken.
      pend_valid = 1'b0;
      pend_pc    = 12'h200;
      for (int i = 0; i < 400; i++) begin
         if (!pend_valid && ($urandom_range(0, 9) < 7)) begin
            pend_valid = 1'b1;
            pend_pc    = pend_pc + 12'h004;
         end
         applyStimulus("rand", pend_valid, pend_pc, ($urandom_range(0, 9) < 6),
                       ($urandom_range(0, 99) < 5), acc);
         if (acc || flushD) pend_valid = 1'b0;
      end

      $display("[TB] %0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
